// File: rtl/openmips_min_sopc_top.sv
`default_nettype none
// ============================================================================
// Module : openmips_min_sopc_top
// Brief  : Boots instruction memory serially from SPI flash, then runs a
//          single-cycle MIPS-subset core (ORI/ADDIU/LUI/BEQ) out of it.
// Rev    : 1.0 - initial release
// ============================================================================
module openmips_min_sopc_top #(
    parameter int BOOT_WORDS = 16,
    parameter int SCK_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flash_sdi,
    output logic        flash_sck,
    output logic        flash_cs_n,
    output logic        boot_done,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] reg_v0
);

    localparam int c_AW = $clog2(BOOT_WORDS);
    localparam int c_DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCK_DIV - 1);
    localparam logic [c_DW-1:0] c_DIV_ONE  = c_DW'(1);
    localparam logic [c_AW-1:0] c_PC_ONE   = c_AW'(1);
    localparam logic [c_AW-1:0] c_WORD_LAST = c_AW'(BOOT_WORDS - 1);

    localparam logic [0:0] c_ST_BOOT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;

    logic [0:0]      r_state_q, w_state_d;
    logic [c_DW-1:0] r_div_q, w_div_d;
    logic            r_sck_q, w_sck_d;
    logic            r_cs_n_q, w_cs_n_d;
    logic [31:0]     r_shift_q, w_shift_d;
    logic [4:0]      r_bit_q, w_bit_d;
    logic [c_AW-1:0] r_word_q, w_word_d;
    logic            r_loaded_q, w_loaded_d;
    logic [c_AW-1:0] r_pc_q, w_pc_d;

    logic [31:0] r_imem_q [BOOT_WORDS];
    logic [31:0] r_rf_q [32];

    logic        w_wrap, w_sample, w_boot_end, w_imem_we;
    logic [31:0] w_imem_wdata;

    logic [31:0] w_inst, w_rs_val, w_rt_val, w_imm_sext;
    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt;
    logic [15:0] w_imm;
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_BOOT;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Boot finishes one clock after the falling sck edge that closes the last bit.
    assign w_wrap     = (r_div_q == c_DIV_LAST);
    assign w_sample   = (r_state_q == c_ST_BOOT) && w_wrap && !r_sck_q && !r_loaded_q;
    assign w_boot_end = r_loaded_q && !r_sck_q && (r_div_q == '0);

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d = r_state_q;
        if (r_state_q == c_ST_BOOT && w_boot_end) begin
            w_state_d = c_ST_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        boot_done = (r_state_q == c_ST_RUN);
    end

    // ---------------- Flash boot datapath ----------------
    always_comb begin
        w_div_d      = r_div_q;
        w_sck_d      = r_sck_q;
        w_shift_d    = r_shift_q;
        w_bit_d      = r_bit_q;
        w_word_d     = r_word_q;
        w_loaded_d   = r_loaded_q;
        w_imem_we    = 1'b0;
        w_imem_wdata = {r_shift_q[30:0], flash_sdi};
        w_cs_n_d     = (w_state_d == c_ST_RUN);
        if (r_state_q == c_ST_BOOT && w_state_d == c_ST_BOOT) begin
            w_div_d = w_wrap ? '0 : r_div_q + c_DIV_ONE;
            if (w_wrap) begin
                w_sck_d = ~r_sck_q;
            end
            if (w_sample) begin
                w_shift_d = {r_shift_q[30:0], flash_sdi};
                w_bit_d   = r_bit_q + 5'd1;
                if (r_bit_q == 5'd31) begin
                    w_imem_we = 1'b1;
                    w_word_d  = r_word_q + c_PC_ONE;
                    if (r_word_q == c_WORD_LAST) begin
                        w_loaded_d = 1'b1;
                    end
                end
            end
        end else begin
            w_div_d = '0;
            w_sck_d = 1'b0;
        end
    end

    // ---------------- Core ----------------
    assign w_inst     = r_imem_q[r_pc_q];
    assign w_op       = w_inst[31:26];
    assign w_rs       = w_inst[25:21];
    assign w_rt       = w_inst[20:16];
    assign w_imm      = w_inst[15:0];
    assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
    assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_rf_q[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_rf_q[w_rt];

    always_comb begin
        w_pc_d     = r_pc_q;
        w_rf_we    = 1'b0;
        w_rf_wdata = 32'd0;
        if (r_state_q == c_ST_RUN) begin
            w_pc_d = r_pc_q + c_PC_ONE;
            case (w_op)
                c_OP_ORI: begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = w_rs_val | {16'h0000, w_imm};
                end
                c_OP_ADDIU: begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = w_rs_val + w_imm_sext;
                end
                c_OP_LUI: begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = {w_imm, 16'h0000};
                end
                c_OP_BEQ: begin
                    // Word-index arithmetic wraps naturally at the imem size.
                    if (w_rs_val == w_rt_val) begin
                        w_pc_d = r_pc_q + c_PC_ONE + w_imm[c_AW-1:0];
                    end
                end
                default: ;
            endcase
            if (w_rt == 5'd0) begin
                w_rf_we = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q    <= '0;
            r_sck_q    <= 1'b0;
            r_cs_n_q   <= 1'b1;
            r_shift_q  <= '0;
            r_bit_q    <= '0;
            r_word_q   <= '0;
            r_loaded_q <= 1'b0;
            r_pc_q     <= '0;
        end else begin
            r_div_q    <= w_div_d;
            r_sck_q    <= w_sck_d;
            r_cs_n_q   <= w_cs_n_d;
            r_shift_q  <= w_shift_d;
            r_bit_q    <= w_bit_d;
            r_word_q   <= w_word_d;
            r_loaded_q <= w_loaded_d;
            r_pc_q     <= w_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_imem_we) begin
            r_imem_q[r_word_q] <= w_imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf_q[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_rf_q[w_rt] <= w_rf_wdata;
        end
    end

    assign flash_sck  = r_sck_q;
    assign flash_cs_n = r_cs_n_q;
    assign pc         = {{(30 - c_AW){1'b0}}, r_pc_q, 2'b00};
    assign inst       = w_inst;
    assign reg_v0     = r_rf_q[2];

endmodule
`default_nettype wire

// File: tb/tb_openmips_min_sopc_top.sv
`default_nettype none
// ============================================================================
// Module : tb_openmips_min_sopc_top
// Brief  : Streams programs over the flash line and checks boot timing and
//          execution against an instruction-level MIPS-subset model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_openmips_min_sopc_top;

    localparam int N         = 16;
    localparam int D         = 4;
    localparam int BOOT_CLKS = N * 32 * 2 * D;
    localparam int PC_MASK   = N * 4 - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flash_sdi = 1'b0;
    logic        flash_sck, flash_cs_n, boot_done;
    logic [31:0] pc, inst, reg_v0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prog [N];
    logic [31:0] mreg [32];
    int          mpc;

    openmips_min_sopc_top #(.BOOT_WORDS(N), .SCK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .flash_sdi  (flash_sdi),
        .flash_sck  (flash_sck),
        .flash_cs_n (flash_cs_n),
        .boot_done  (boot_done),
        .pc         (pc),
        .inst       (inst),
        .reg_v0     (reg_v0)
    );

    always #5 clk = ~clk;

    task automatic clear_prog();
        for (int i = 0; i < N; i++) prog[i] = 32'h0;
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({flash_cs_n, flash_sck, boot_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL %s_ctl: cs_n/sck/done got %b expected 100", tag, {flash_cs_n, flash_sck, boot_done});
        end
        n_cmp++;
        if (pc !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_pc: got %h expected 00000000", tag, pc);
        end
        n_cmp++;
        if (reg_v0 !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_v0: got %h expected 00000000", tag, reg_v0);
        end
        rst = 1'b0;
    endtask

    // Called right after the negedge where rst was released; edge k is the k-th posedge after that.
    task automatic boot_stream(input string tag);
        int   g;
        logic exp_sck;
        for (int k = 1; k <= BOOT_CLKS; k++) begin
            g = (k - 1) / (2 * D);
            flash_sdi = prog[g / 32][31 - (g % 32)];
            @(negedge clk);
            exp_sck = ((k / D) % 2) == 1;
            n_cmp++;
            if ({flash_cs_n, flash_sck, boot_done} !== {1'b0, exp_sck, 1'b0}) begin
                n_bad++;
                $display("FAIL %s_boot_clk%0d: cs_n/sck/done got %b expected %b", tag, k,
                         {flash_cs_n, flash_sck, boot_done}, {1'b0, exp_sck, 1'b0});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({flash_cs_n, flash_sck, boot_done} !== 3'b101 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_enter_run: cs_n/sck/done got %b pc %h expected 101 pc 00000000", tag,
                     {flash_cs_n, flash_sck, boot_done}, pc);
        end
        mpc = 0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    endtask

    task automatic run_check(input string tag, input int cycles);
        logic [31:0] i, sx, v;
        logic [5:0]  op;
        int          rs, rt, npc;
        bit          we;
        for (int c = 0; c < cycles; c++) begin
            flash_sdi = 1'($urandom_range(0, 1));
            i = prog[mpc / 4];
            n_cmp++;
            if (pc !== 32'(mpc)) begin
                n_bad++;
                $display("FAIL %s_pc_c%0d: got %h expected %h", tag, c, pc, 32'(mpc));
            end
            n_cmp++;
            if (inst !== i) begin
                n_bad++;
                $display("FAIL %s_inst_c%0d: got %h expected %h", tag, c, inst, i);
            end
            n_cmp++;
            if (reg_v0 !== mreg[2]) begin
                n_bad++;
                $display("FAIL %s_v0_c%0d: got %h expected %h", tag, c, reg_v0, mreg[2]);
            end
            op  = i[31:26];
            rs  = int'(i[25:21]);
            rt  = int'(i[20:16]);
            sx  = {{16{i[15]}}, i[15:0]};
            npc = (mpc + 4) & PC_MASK;
            we  = 1'b0;
            v   = 32'h0;
            case (op)
                6'h0D: begin we = 1'b1; v = mreg[rs] | {16'h0, i[15:0]}; end
                6'h09: begin we = 1'b1; v = mreg[rs] + sx; end
                6'h0F: begin we = 1'b1; v = {i[15:0], 16'h0}; end
                6'h04: if (mreg[rs] == mreg[rt])
                           npc = int'((32'(mpc) + 32'd4 + (sx << 2)) & 32'(PC_MASK));
                default: ;
            endcase
            if (we && rt != 0) mreg[rt] = v;
            mpc = npc;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_stream();
        clear_prog();
        test_reset("zero_rst");
        boot_stream("zero");
        run_check("zero", 40);
    endtask

    task automatic test_ori();
        clear_prog();
        prog[0] = 32'h34020055;
        test_reset("ori_rst");
        boot_stream("ori");
        run_check("ori", 1);
        n_cmp++;
        if (reg_v0 !== 32'h00000055) begin
            n_bad++;
            $display("FAIL ori_first: got %h expected 00000055", reg_v0);
        end
        run_check("ori", 10);
    endtask

    task automatic test_loop();
        clear_prog();
        prog[0] = 32'h34020055;
        prog[1] = 32'h24420001;
        prog[2] = 32'h1000FFFE;
        test_reset("loop_rst");
        boot_stream("loop");
        run_check("loop", 30);
        test_reset("midrun_rst");
    endtask

    task automatic test_lui_addiu();
        clear_prog();
        prog[0] = 32'h3C02ABCD;
        prog[1] = 32'h3442FFFF;
        prog[2] = 32'h2402FFFF;
        prog[3] = 32'h24420001;
        test_reset("lui_rst");
        boot_stream("lui");
        run_check("lui", 4);
        n_cmp++;
        if (reg_v0 !== 32'h00000000) begin
            n_bad++;
            $display("FAIL addiu_wrap: got %h expected 00000000", reg_v0);
        end
        run_check("lui", 20);
    endtask

    task automatic test_branch_self();
        clear_prog();
        prog[0] = 32'h34000077;
        prog[1] = 32'h34020001;
        prog[2] = 32'h1000FFFF;
        test_reset("self_rst");
        boot_stream("self");
        run_check("self", 10);
        n_cmp++;
        if (pc !== 32'h8 || reg_v0 !== 32'h1) begin
            n_bad++;
            $display("FAIL self_hold: pc %h v0 %h expected pc 00000008 v0 00000001", pc, reg_v0);
        end
    endtask

    task automatic rand_prog();
        logic [5:0] op;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 4))
                0: op = 6'h0D;
                1: op = 6'h09;
                2: op = 6'h0F;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            prog[i] = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            rand_prog();
            test_reset("rand_rst");
            boot_stream("rand");
            run_check("rand", 64);
        end
    endtask

    task automatic test_reset_mid_boot();
        test_reset("midboot_rst0");
        for (int k = 1; k <= 1000; k++) begin
            if (k % 5 == 0) flash_sdi = ~flash_sdi;
            @(negedge clk);
            n_cmp++;
            if (flash_cs_n !== 1'b0) begin
                n_bad++;
                $display("FAIL midboot_cs_clk%0d: got %b expected 0", k, flash_cs_n);
            end
        end
        rand_prog();
        test_reset("midboot_rst1");
        boot_stream("midboot");
        run_check("midboot", 32);
    endtask

    initial begin
        test_reset("init_rst");
        test_zero_stream();
        test_ori();
        test_loop();
        test_lui_addiu();
        test_branch_self();
        test_random();
        test_reset_mid_boot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/openmips_min_sopc_top.md
# openmips_min_sopc_top

Minimal system-on-programmable-chip top level. It boots a small instruction memory serially from an external SPI flash data line, then runs a tiny single-cycle MIPS-subset core out of that memory. It is the top of the CPU design, and its only required input besides clock and reset is the flash serial data line. The outputs are a flash clock, a flash chip-select and debug visibility ports; all outputs may be left unconnected.

## Interface
- BOOT_WORDS, 16: number of 32-bit words loaded from flash and the instruction-memory depth. Power of two, 2..64.
- SCK_DIV, 4: number of clk cycles per flash_sck half-period. Minimum 1.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- flash_sdi  in  1  serial data from flash, MSB-first.
- flash_sck  out  1  flash serial clock.
- flash_cs_n  out  1  flash chip select, active-low.
- boot_done  out  1  high once the core is running.
- pc  out  32  current program counter (byte address).
- inst  out  32  instruction at pc (combinational read of instruction memory).
- reg_v0  out  32  contents of register r2.

## Operation
- Two states: BOOT and RUN. Reset forces BOOT.
- **BOOT**
  - flash_cs_n=0.
  - A divider counts 0..SCK_DIV-1. flash_sck toggles on the clock where the divider wraps.
  - On each 0->1 toggle of flash_sck, the clk edge samples flash_sdi into a 32-bit shift register (MSB first) and increments the bit counter.
  - On the 32nd bit of a word, write {shift[30:0], flash_sdi} to imem[word_idx], then increment word_idx.
  - After word BOOT_WORDS-1 is written, the next clock enters RUN with flash_cs_n=1, flash_sck=0, boot_done=1, pc=0.
- **RUN** (one instruction per clock)
  - Decode inst = imem[pc[log2(BOOT_WORDS)+1:2]].
  - 32x32 register file; r0 always reads 0 and writes to it are discarded.
  - opcode 0x0D ORI: rt = rs | zext(imm16).
  - 0x09 ADDIU: rt = rs + sext(imm16), modulo 2^32, no overflow trap.
  - 0x0F LUI: rt = {imm16, 16'h0}.
  - 0x04 BEQ: if rs==rt, pc = pc+4+(sext(imm16)<<2). There is no delay slot.
  - Any other opcode executes as a NOP.
  - Default next pc = pc+4. pc wraps modulo BOOT_WORDS*4; upper pc bits are always 0.
- flash_sdi is ignored in RUN. Imem is written only in BOOT.

## Timing
- Reset values:
  - flash_cs_n=1, flash_sck=0, boot_done=0, pc=0, reg_v0=0.
  - All registers are 0; divider, bit and word counters are 0.
  - Imem is not cleared.
- First clock with rst low: flash_cs_n goes 0. flash_sck first rises after 2*SCK_DIV... more precisely, it rises after SCK_DIV clocks low.
- Bit period is 2*SCK_DIV clocks.
- Boot length: BOOT_WORDS*32*2*SCK_DIV clocks after reset release, plus 1 clock to enter RUN. The default is 4096+1.
- RUN: a register write is visible on reg_v0 the cycle after the instruction. pc updates every clock.
- rst asserted mid-boot or mid-run restarts BOOT from word 0 and bit 0 on the next edge. Registers are cleared.
- Boundaries:
  - The BEQ target wraps modulo imem size.
  - A branch to itself (imm=0xFFFF) holds pc.
  - Writing rt=r0 has no effect.

## Test plan
- flash_sdi held 0, defaults: boot_done rises exactly 4097 clocks after rst falls. After that, pc increments by 4 per clock and wraps 0x3C -> 0x00. reg_v0 stays 0.
- Stream word0=0x34020055 (ORI r2,r0,0x55), rest 0: at RUN cycle 1, reg_v0=0x00000055.
- Stream 0x34020055, 0x24420001, 0x1000FFFE:
  - pc sequence is 0,4,8,4,8,...
  - reg_v0 = 0x55, 0x56, 0x57, ..., incrementing once every 2 clocks.
- Stream 0x3C02ABCD (LUI) then 0x3442FFFF (ORI): reg_v0=0xABCD0000, then 0xABCDFFFF.
- 0x2402FFFF (ADDIU r2,r0,-1) then 0x24420001: reg_v0=0xFFFFFFFF, then 0x00000000 (wrap).
- Toggle flash_sdi every 5 clocks, assert rst for 1 clock mid-boot (e.g. at clock 1000): flash_cs_n stays 0 after reset, and boot_done rises 4097 clocks after the second reset release.
